// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Data-memory responder for the pipeline memory stage. One load/store request
//   is accepted at a time over a valid/ready handshake. The access is made a
//   fixed LATENCY after accept, and the result goes out over a second
//   valid/ready handshake.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (byte addresses 0 .. 4*DEPTH_WORDS-1)
//   LATENCY     : cycles from request accept to resp_valid (1..15)
//
// Ports
//   clk, rst                  : rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready     : request handshake (req_ready high only in IDLE)
//   req_write                 : 1 = store, 0 = load
//   req_addr                  : byte address
//   req_wdata                 : store data, byte/half taken from the low bits
//   req_size                  : 00 word, 01 half, 10 byte, 11 illegal
//   req_signed                : load sign-extension select (byte/half only)
//   resp_valid / resp_ready   : response handshake
//   resp_rdata                : extended load data, 0 for stores and errors
//   resp_err                  : misaligned, out-of-range or illegal-size request
// -----------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;

    // Captured request
    logic        cap_write_r;
    logic [31:0] cap_addr_r;
    logic [31:0] cap_wdata_r;
    logic [1:0]  cap_size_r;
    logic        cap_signed_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Access operands and results
    logic        acc_write_s;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic [1:0]  acc_size_s;
    logic        acc_signed_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0] rd_word_s;
    logic        err_s;
    logic        access_s;
    logic        mem_we_s;
    logic [31:0] resp_data_s;

    // Select the lane(s) of a word and extend to 32 bits (little-endian).
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = word;
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = {{24{sgn & b[7]}}, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Merge store data into the old word; unaddressed lanes keep their value.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: r = wdata;
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            2'b10:   r[{lane, 3'b000} +: 8] = wdata[7:0];
            default: r = old;
        endcase
        return r;
    endfunction

    // Illegal size, misalignment or out-of-range address.
    function automatic logic check_error(input logic [31:0] addr,
                                         input logic [1:0]  size);
        logic e;
        e = 1'b0;
        case (size)
            2'b00:   e = (addr[1:0] != 2'b00);
            2'b01:   e = addr[0];
            2'b10:   e = 1'b0;
            default: e = 1'b1;
        endcase
        return e | (addr >= ADDR_LIMIT);
    endfunction

    // With LATENCY=1 the access happens on the accept edge itself, so it must
    // use the live request; otherwise it uses the captured copy.
    always_comb begin
        if (LATENCY == 1) begin
            acc_write_s  = req_write;
            acc_addr_s   = req_addr;
            acc_wdata_s  = req_wdata;
            acc_size_s   = req_size;
            acc_signed_s = req_signed;
            access_s     = (state_r == ST_IDLE) && req_valid;
        end else begin
            acc_write_s  = cap_write_r;
            acc_addr_s   = cap_addr_r;
            acc_wdata_s  = cap_wdata_r;
            acc_size_s   = cap_size_r;
            acc_signed_s = cap_signed_r;
            access_s     = (state_r == ST_WAIT) && (cnt_r == 4'd0);
        end
    end

    // Word lookup, error detection and response data formation.
    always_comb begin
        idx_s     = acc_addr_s[IDX_W+1:2];
        rd_word_s = mem_r[idx_s];
        err_s     = check_error(acc_addr_s, acc_size_s);
        mem_we_s  = access_s && acc_write_s && !err_s;
        if (acc_write_s || err_s) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = load_extract(rd_word_s, acc_addr_s[1:0], acc_size_s, acc_signed_s);
        end
    end

    // Memory array: not reset, written only on the access edge of a legal store.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= store_merge(rd_word_s, acc_wdata_s, acc_addr_s[1:0], acc_size_s);
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            cap_write_r  <= 1'b0;
            cap_addr_r   <= 32'h0000_0000;
            cap_wdata_r  <= 32'h0000_0000;
            cap_size_r   <= 2'b00;
            cap_signed_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_write_r  <= req_write;
                        cap_addr_r   <= req_addr;
                        cap_wdata_r  <= req_wdata;
                        cap_size_r   <= req_size;
                        cap_signed_r <= req_signed;
                        req_ready_r  <= 1'b0;
                        if (LATENCY == 1) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= resp_data_s;
                            resp_err_r   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 4'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= resp_data_s;
                        resp_err_r   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // req_ready rises with the state change, so nothing is
                    // accepted in the retiring cycle.
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        req_ready_r  <= 1'b1;
                        resp_valid_r <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                        resp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule
